// File: rtl/register.sv
// ----------------------------------------------------------------------------
// register -- single WIDTH-bit storage register with load enable.
//
// Holds one WIDTH-bit value. On each rising edge of clk:
//   reset = 1            -> stored value becomes RESET_VALUE (reset beats write)
//   reset = 0, write = 1 -> stored value becomes in
//   reset = 0, write = 0 -> stored value is held
// out is driven straight from the storage flops, so there is no combinational
// path from in, write or reset to out, and the write latency is one cycle.
//
// Parameters:
//   WIDTH       data width of in and out (default 16)
//   RESET_VALUE value loaded by reset (default all zeros)
//
// Ports:
//   clk    input            single clock, rising-edge active
//   reset  input            synchronous, active-high reset
//   in     input  [WIDTH]   data to be stored
//   write  input            load enable, active-high
//   out    output [WIDTH]   current stored value
// ----------------------------------------------------------------------------
module register #(
    parameter int unsigned           WIDTH       = 16,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             write,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= RESET_VALUE;
        end else if (write) begin
            out <= in;
        end
    end

endmodule

// File: tb/tb_register.sv
// ----------------------------------------------------------------------------
// tb_register -- directed, table-driven bench for register.
//
// Inputs are driven just after a falling edge, captured at the following
// rising edge, and out is checked at the next falling edge. A second instance
// with WIDTH=8 and a non-zero RESET_VALUE sees the low byte of the same
// stimulus. Hand-written sequences cover glitches between rising edges and
// the one-cycle write latency.
// ----------------------------------------------------------------------------
module tb_register;

    logic        clk;
    logic        reset;
    logic        write;
    logic [15:0] d_in;
    logic [15:0] q_out;
    logic [7:0]  q_out8;

    int unsigned total;
    int unsigned bad;

    register dut (
        .clk   (clk),
        .reset (reset),
        .in    (d_in),
        .write (write),
        .out   (q_out)
    );

    register #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) dut8 (
        .clk   (clk),
        .reset (reset),
        .in    (d_in[7:0]),
        .write (write),
        .out   (q_out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        reset;
        logic        write;
        logic [15:0] d_in;
        logic [15:0] exp16;
        logic [7:0]  exp8;
    } vec_t;

    vec_t vecs[19];

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        write = 1'b0;
        d_in  = 16'h0000;

        //            reset write  in        out16     out8
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 8'hA5};  // reset
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 8'hA5};  // stays at reset value
        vecs[2]  = '{1'b0, 1'b1, 16'hABCD, 16'hABCD, 8'hCD};  // write
        vecs[3]  = '{1'b0, 1'b0, 16'hABCD, 16'hABCD, 8'hCD};  // hold
        vecs[4]  = '{1'b0, 1'b0, 16'hABCD, 16'hABCD, 8'hCD};  // hold
        vecs[5]  = '{1'b0, 1'b1, 16'h1111, 16'h1111, 8'h11};  // overwrite
        vecs[6]  = '{1'b1, 1'b0, 16'h1111, 16'h0000, 8'hA5};  // reset mid-operation
        vecs[7]  = '{1'b0, 1'b0, 16'h1111, 16'h0000, 8'hA5};  // old data not recovered
        vecs[8]  = '{1'b0, 1'b1, 16'h1234, 16'h1234, 8'h34};
        vecs[9]  = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 8'hA5};  // reset beats write
        vecs[10] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 8'hA5};
        vecs[11] = '{1'b0, 1'b1, 16'h8001, 16'h8001, 8'h01};  // MSB kept, no sign games
        vecs[12] = '{1'b0, 1'b0, 16'h5A5A, 16'h8001, 8'h01};  // toggling input, hold
        vecs[13] = '{1'b0, 1'b0, 16'hA5A5, 16'h8001, 8'h01};
        vecs[14] = '{1'b0, 1'b0, 16'h5A5A, 16'h8001, 8'h01};
        vecs[15] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 8'hFF};  // back-to-back writes
        vecs[16] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 8'h00};
        vecs[17] = '{1'b0, 1'b1, 16'hC3C3, 16'hC3C3, 8'hC3};
        vecs[18] = '{1'b0, 1'b0, 16'h0000, 16'hC3C3, 8'hC3};

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            #1;
            reset = vecs[i].reset;
            write = vecs[i].write;
            d_in  = vecs[i].d_in;
            @(negedge clk);
            check16($sformatf("vec%0d_out16", i), q_out, vecs[i].exp16);
            check8($sformatf("vec%0d_out8", i), q_out8, vecs[i].exp8);
        end

        // out is 0xC3C3 here. Reset pulse that covers no rising edge.
        #1;
        write = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clk);
        check16("reset_glitch_16", q_out, 16'hC3C3);
        check8("reset_glitch_8", q_out8, 8'hC3);

        // Write pulse and data change between rising edges.
        #1;
        d_in  = 16'h7777;
        write = 1'b1;
        #2;
        write = 1'b0;
        d_in  = 16'h0F0F;
        @(negedge clk);
        check16("write_glitch_16", q_out, 16'hC3C3);

        // One-cycle latency: new value visible just after the capturing edge.
        #1;
        d_in  = 16'h2468;
        write = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
        d_in  = 16'h0000;
        check16("latency_post_edge", q_out, 16'h2468);
        @(negedge clk);
        check16("latency_negedge", q_out, 16'h2468);
        @(negedge clk);
        check16("latency_hold", q_out, 16'h2468);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register.md
REGISTER -- requirements
Module: register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the data width in bits of in and out.
REQ-002 The block SHALL have parameter RESET_VALUE, default 0 (WIDTH bits), the value loaded into the register by reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in, input, WIDTH bits: data to be stored.
REQ-006 The block SHALL have port write, input, 1 bit: load enable, active-high.
REQ-007 The block SHALL have port out, output, WIDTH bits: the current stored value, driven directly from the storage flops.
REQ-008 The block SHALL have one clock and a synchronous, active-high reset, with the ports named clk and reset.

Function
REQ-009 The block SHALL hold one WIDTH-bit storage element, updated only on the rising edge of clk.
REQ-010 On a rising clk edge with reset=1, the stored value SHALL become RESET_VALUE, regardless of write and in.
REQ-011 On a rising clk edge with reset=0 and write=1, the stored value SHALL become in as sampled at that edge.
REQ-012 On a rising clk edge with reset=0 and write=0, the stored value SHALL be unchanged.
REQ-013 Write latency SHALL be one cycle: out reflects the new value immediately after the capturing edge and is stable before the following falling edge.
REQ-014 out SHALL equal the stored value at all times, with no combinational path from in, write or reset to out.
REQ-015 Changes on in, write or reset between rising edges SHALL have no effect on out.
REQ-016 Consecutive write=1 cycles SHALL each load that cycle's in, so back-to-back writes are fully supported with no bubble.
REQ-017 When reset and write are asserted on the same edge, reset SHALL win and out SHALL become RESET_VALUE.
REQ-018 Reset asserted while data is held SHALL clear the data at the next rising edge, and the value before reset SHALL NOT be recoverable.
REQ-019 After reset deasserts, out SHALL remain RESET_VALUE until the first edge with write=1.
REQ-020 All WIDTH bits SHALL be stored and returned unmodified: no sign extension, truncation or arithmetic.
REQ-021 The contents before the first reset edge are unspecified, and the block SHALL NOT rely on initial values.
REQ-022 The block SHALL be synthesizable: no latches, no delays, and no asynchronous set or clear.

Reset
REQ-023 With reset held high across at least one rising clk edge, out SHALL read RESET_VALUE (0x0000 by default) after that edge.
REQ-024 Reset SHALL be sampled only at rising clk edges, so a reset pulse that covers no rising edge has no effect.
REQ-025 Reset SHALL be the highest-priority control, above write.

Verification
REQ-026 The bench SHALL check reset: hold reset=1, write=0 and in=0x0000 through a rising edge, then release reset; out SHALL be 0x0000.
REQ-027 The bench SHALL check a write followed by a hold:
- at a falling edge, drive in=0xABCD and write=1;
- at the next falling edge, drop write to 0; out SHALL be 0xABCD;
- one cycle later, out SHALL still be 0xABCD.
REQ-028 The bench SHALL check an overwrite: with out=0xABCD, drive in=0x1111 and write=1 for one cycle; out SHALL be 0x1111 at the next falling edge.
REQ-029 The bench SHALL check reset mid-operation: with out=0x1111, apply reset=1 and write=0 for one cycle, then release reset; out SHALL be 0x0000.
REQ-030 The bench SHALL check simultaneous reset and write: drive reset=1, write=1 and in=0xFFFF for one edge; out SHALL be 0x0000.
REQ-031 The bench SHALL check hold with a toggling input: with write=0, change in to 0x5A5A and then 0xA5A5 on several edges; out SHALL keep its prior value every cycle.
